// File: rtl/spectrum_bar_mapper.sv
// spectrum_bar_mapper
//
// Turns 16 unsigned FFT bin magnitudes into 5-bit log-style bar heights
// (0..31) for a spectrum display, with optional per-bar peak hold and decay.
//
// Operation: a done strobe in IDLE snapshots f0..f15. The FSM then converts
// one bin per cycle into a shadow register (PROC, 16 cycles). It then
// publishes all 16 heights at once (PUBLISH) with a one-cycle frame_valid.
// done-to-frame_valid latency is 17 cycles.
//
// done handshake: done is a single-cycle strobe with no backpressure. It is
// accepted only in IDLE. A done seen in PROC or PUBLISH, including the
// PUBLISH->IDLE edge, is dropped and counted in overrun, which saturates
// at 255.
//
// Ports
//   clk          system clock (rising edge)
//   reset        asynchronous active-low reset; release synchronised to clk
//   done         frame-ready strobe from the FFT processor
//   f0..f15      bin magnitudes, unsigned 16-bit
//   h0..h15      published bar heights, 0..31
//   p0..p15      published peak-hold heights (constant 0 without peak hold)
//   frame_valid  one-cycle pulse when h*/p* update
//   busy         high while a frame is in PROC or PUBLISH
//   overrun      saturating count of dropped done pulses
//
// Parameter DECAY_DIV (1..255): published frames per one-step peak decrement.
// Macro SPECTRUM_PEAK_HOLD_EN: when defined, builds the peak registers and
// the decay counter. Otherwise p0..p15 are tied to 0.
module spectrum_bar_mapper #(
  parameter int DECAY_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  input  logic [15:0] f0,  input  logic [15:0] f1,  input  logic [15:0] f2,  input  logic [15:0] f3,
  input  logic [15:0] f4,  input  logic [15:0] f5,  input  logic [15:0] f6,  input  logic [15:0] f7,
  input  logic [15:0] f8,  input  logic [15:0] f9,  input  logic [15:0] f10, input  logic [15:0] f11,
  input  logic [15:0] f12, input  logic [15:0] f13, input  logic [15:0] f14, input  logic [15:0] f15,
  output logic [4:0]  h0,  output logic [4:0]  h1,  output logic [4:0]  h2,  output logic [4:0]  h3,
  output logic [4:0]  h4,  output logic [4:0]  h5,  output logic [4:0]  h6,  output logic [4:0]  h7,
  output logic [4:0]  h8,  output logic [4:0]  h9,  output logic [4:0]  h10, output logic [4:0]  h11,
  output logic [4:0]  h12, output logic [4:0]  h13, output logic [4:0]  h14, output logic [4:0]  h15,
  output logic [4:0]  p0,  output logic [4:0]  p1,  output logic [4:0]  p2,  output logic [4:0]  p3,
  output logic [4:0]  p4,  output logic [4:0]  p5,  output logic [4:0]  p6,  output logic [4:0]  p7,
  output logic [4:0]  p8,  output logic [4:0]  p9,  output logic [4:0]  p10, output logic [4:0]  p11,
  output logic [4:0]  p12, output logic [4:0]  p13, output logic [4:0]  p14, output logic [4:0]  p15,
  output logic        frame_valid,
  output logic        busy,
  output logic [7:0]  overrun
);

  if (DECAY_DIV < 1 || DECAY_DIV > 255) begin : g_bad_decay_div
    $error("DECAY_DIV must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PROC    = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  // Height = min(31, 2*msb + next_bit + 1). Zero input maps to 0.
  function automatic logic [4:0] bar_height(input logic [15:0] v);
    logic [3:0] msb;
    logic       nb;
    logic [5:0] sum;
    msb = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) msb = 4'(i);
    end
    nb  = (msb != 4'd0) ? v[msb - 4'd1] : 1'b0;
    sum = {1'b0, msb, 1'b0} + {5'b0, nb} + 6'd1;
    if (v == 16'd0)       return 5'd0;
    else if (sum > 6'd31) return 5'd31;
    else                  return sum[4:0];
  endfunction

  // Reset: asserts asynchronously, deasserts after two clk edges.
  logic r_rst_meta;
  logic r_rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  logic [255:0] w_f;
  assign w_f = {f15, f14, f13, f12, f11, f10, f9, f8, f7, f6, f5, f4, f3, f2, f1, f0};

  state_t      r_state;
  logic [3:0]  r_bin;
  logic [15:0] r_snap   [16];
  logic [4:0]  r_shadow [16];
  logic [79:0] r_h;
  logic        r_fv;
  logic        r_busy;
  logic [7:0]  r_ovr;
  logic [4:0]  w_height;

  assign w_height = bar_height(r_snap[r_bin]);

  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state <= S_IDLE;
      r_bin   <= 4'd0;
      r_h     <= '0;
      r_fv    <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 8'd0;
      for (int i = 0; i < 16; i++) begin
        r_snap[i]   <= 16'd0;
        r_shadow[i] <= 5'd0;
      end
    end else begin
      r_fv <= 1'b0;
      if (done && (r_state != S_IDLE) && (r_ovr != 8'hFF)) r_ovr <= r_ovr + 8'd1;
      case (r_state)
        S_IDLE: begin
          if (done) begin
            for (int i = 0; i < 16; i++) r_snap[i] <= w_f[i*16 +: 16];
            r_bin   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= S_PROC;
          end
        end
        S_PROC: begin
          r_shadow[r_bin] <= w_height;
          r_bin           <= r_bin + 4'd1;
          if (r_bin == 4'd15) r_state <= S_PUBLISH;
        end
        S_PUBLISH: begin
          for (int i = 0; i < 16; i++) r_h[i*5 +: 5] <= r_shadow[i];
          r_fv    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign {h15, h14, h13, h12, h11, h10, h9, h8, h7, h6, h5, h4, h3, h2, h1, h0} = r_h;
  assign frame_valid = r_fv;
  assign busy        = r_busy;
  assign overrun     = r_ovr;

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam logic [7:0] LP_DECAY_LAST = 8'(DECAY_DIV - 1);

  logic [79:0] r_p;
  logic [7:0]  r_decay;
  logic [7:0]  w_decay_next;
  logic        w_decay_frame;

  // A decay frame is a publish on which the frame counter wraps to 0.
  assign w_decay_next  = (r_decay == LP_DECAY_LAST) ? 8'd0 : r_decay + 8'd1;
  assign w_decay_frame = (w_decay_next == 8'd0);

  // Peaks use the shadow heights, which become h* on this same edge.
  // The decay branch only runs when the peak is above the new height,
  // so the peak is at least 1 and the minus-one cannot underflow.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_p     <= '0;
      r_decay <= 8'd0;
    end else if (r_state == S_PUBLISH) begin
      r_decay <= w_decay_next;
      for (int i = 0; i < 16; i++) begin
        if (r_shadow[i] >= r_p[i*5 +: 5]) begin
          r_p[i*5 +: 5] <= r_shadow[i];
        end else if (w_decay_frame) begin
          r_p[i*5 +: 5] <= (r_shadow[i] > r_p[i*5 +: 5] - 5'd1) ? r_shadow[i]
                                                                : r_p[i*5 +: 5] - 5'd1;
        end
      end
    end
  end

  assign {p15, p14, p13, p12, p11, p10, p9, p8, p7, p6, p5, p4, p3, p2, p1, p0} = r_p;
`else
  assign {p15, p14, p13, p12, p11, p10, p9, p8, p7, p6, p5, p4, p3, p2, p1, p0} = '0;
`endif

endmodule

// File: tb/tb_spectrum_bar_mapper.sv
module tb_spectrum_bar_mapper;

  localparam int DECAY_DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic done  = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] f_in [16];
  logic [4:0]  h0, h1, h2, h3, h4, h5, h6, h7, h8, h9, h10, h11, h12, h13, h14, h15;
  logic [4:0]  p0, p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15;
  logic        frame_valid;
  logic        busy;
  logic [7:0]  overrun;
  logic [79:0] h_all;
  logic [79:0] p_all;

  assign h_all = {h15, h14, h13, h12, h11, h10, h9, h8, h7, h6, h5, h4, h3, h2, h1, h0};
  assign p_all = {p15, p14, p13, p12, p11, p10, p9, p8, p7, p6, p5, p4, p3, p2, p1, p0};

  spectrum_bar_mapper #(.DECAY_DIV(DECAY_DIV)) dut (
    .clk(clk), .reset(reset), .done(done),
    .f0(f_in[0]),   .f1(f_in[1]),   .f2(f_in[2]),   .f3(f_in[3]),
    .f4(f_in[4]),   .f5(f_in[5]),   .f6(f_in[6]),   .f7(f_in[7]),
    .f8(f_in[8]),   .f9(f_in[9]),   .f10(f_in[10]), .f11(f_in[11]),
    .f12(f_in[12]), .f13(f_in[13]), .f14(f_in[14]), .f15(f_in[15]),
    .h0(h0), .h1(h1), .h2(h2), .h3(h3), .h4(h4), .h5(h5), .h6(h6), .h7(h7),
    .h8(h8), .h9(h9), .h10(h10), .h11(h11), .h12(h12), .h13(h13), .h14(h14), .h15(h15),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7),
    .p8(p8), .p9(p9), .p10(p10), .p11(p11), .p12(p12), .p13(p13), .p14(p14), .p15(p15),
    .frame_valid(frame_valid), .busy(busy), .overrun(overrun)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_h [16];
  logic [4:0] exp_p [16];
  int         model_cnt;
  logic [4:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      exp_h[i] = 5'd0;
      exp_p[i] = 5'd0;
    end
    model_cnt = 0;
  endtask

  // Reference peak-hold behaviour applied once per published frame.
  task automatic model_publish();
    model_cnt = (model_cnt == DECAY_DIV - 1) ? 0 : model_cnt + 1;
`ifdef SPECTRUM_PEAK_HOLD_EN
    for (int i = 0; i < 16; i++) begin
      if (exp_h[i] >= exp_p[i])  exp_p[i] = exp_h[i];
      else if (model_cnt == 0)   exp_p[i] = (exp_h[i] > exp_p[i] - 5'd1) ? exp_h[i] : exp_p[i] - 5'd1;
    end
`endif
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("%s_h%0d", tag, i), {27'd0, h_all[i*5 +: 5]}, {27'd0, exp_h[i]});
      check($sformatf("%s_p%0d", tag, i), {27'd0, p_all[i*5 +: 5]}, {27'd0, exp_p[i]});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Conversion pattern with hand-computed heights.
  task automatic load_pattern();
    logic [15:0] fv [16];
    logic [4:0]  hv [16];
    fv = '{16'h0000, 16'h0001, 16'h0100, 16'h0180, 16'h8000, 16'hFFFF, 16'h0003, 16'h0002,
           16'h4000, 16'h6000, 16'h0010, 16'h0004, 16'h0007, 16'h0000, 16'h0000, 16'h0000};
    hv = '{5'd0, 5'd1, 5'd17, 5'd18, 5'd31, 5'd31, 5'd4, 5'd3,
           5'd29, 5'd30, 5'd9, 5'd5, 5'd6, 5'd0, 5'd0, 5'd0};
    for (int i = 0; i < 16; i++) begin
      f_in[i]  = fv[i];
      exp_h[i] = hv[i];
    end
  endtask

  // Pulses done for capture edge N, then samples at the negedge after edges
  // N..N+25. extra[k] drives done high again for edge N+k. scramble sets all
  // inputs to 0xFFFF right after the capture edge.
  task automatic run_frame(input logic [31:0] extra, input logic scramble,
                           output int fv_at, output int fv_cnt, output int busy_cnt);
    fv_at = -1; fv_cnt = 0; busy_cnt = 0;
    @(negedge clk);
    done = 1'b1;
    for (int j = 0; j < 26; j++) begin
      @(negedge clk);
      done = extra[j+1];
      if (scramble && j == 0) for (int i = 0; i < 16; i++) f_in[i] = 16'hFFFF;
      if (frame_valid) begin
        fv_cnt++;
        if (fv_at < 0) fv_at = j;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic count_fv(input int n, output int fv_cnt);
    fv_cnt = 0;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (frame_valid) fv_cnt++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int fv_at, fv_cnt, busy_cnt;
    logic [4:0] p0_exp;

    for (int i = 0; i < 16; i++) f_in[i] = 16'd0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs("rst");
    check("rst_fv", {31'd0, frame_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovr", {24'd0, overrun}, 32'd0);

    // done on the first edge after release must be ignored
    reset = 1'b1;
    done  = 1'b1;
    @(negedge clk);
    done = 1'b0;
    count_fv(25, fv_cnt);
    check("early_done_fv", fv_cnt, 32'd0);
    check("early_done_ovr", {24'd0, overrun}, 32'd0);

    // Conversion
    load_pattern();
    run_frame(32'd0, 1'b0, fv_at, fv_cnt, busy_cnt);
    check("conv_fv_at", fv_at, 32'd17);
    check("conv_fv_cnt", fv_cnt, 32'd1);
    check("conv_busy", busy_cnt, 32'd17);
    model_publish();
    check_outputs("conv");

    // Overrun: extra done at N+5 and at the PUBLISH->IDLE edge N+17
    run_frame((32'd1 << 5) | (32'd1 << 17), 1'b0, fv_at, fv_cnt, busy_cnt);
    check("ovr_fv_at", fv_at, 32'd17);
    check("ovr_fv_cnt", fv_cnt, 32'd1);
    check("ovr_busy", busy_cnt, 32'd17);
    check("ovr_count", {24'd0, overrun}, 32'd2);
    model_publish();
    check_outputs("ovr");

    // Input isolation
    load_pattern();
    run_frame(32'd0, 1'b1, fv_at, fv_cnt, busy_cnt);
    check("iso_fv_at", fv_at, 32'd17);
    model_publish();
    check_outputs("iso");

    // Reset in the middle of a frame
    for (int i = 0; i < 16; i++) f_in[i] = 16'h0001;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst");
    check("midrst_ovr", {24'd0, overrun}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_fv", {31'd0, frame_valid}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    count_fv(25, fv_cnt);
    check("midrst_no_fv", fv_cnt, 32'd0);
    run_frame(32'd0, 1'b0, fv_at, fv_cnt, busy_cnt);
    check("postrst_fv_at", fv_at, 32'd17);
    check("postrst_fv_cnt", fv_cnt, 32'd1);
    for (int i = 0; i < 16; i++) exp_h[i] = 5'd1;
    model_publish();
    check_outputs("postrst");

    // Peak decay: one full-scale frame, then 12 silent frames
    apply_reset();
`ifdef SPECTRUM_PEAK_HOLD_EN
    exp_q = '{5'd31, 5'd31, 5'd31, 5'd30, 5'd30, 5'd30, 5'd30, 5'd29, 5'd29, 5'd29, 5'd29, 5'd28, 5'd28};
`else
    exp_q = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
`endif
    for (int i = 0; i < 16; i++) f_in[i] = 16'd0;
    for (int k = 0; k < 13; k++) begin
      f_in[0] = (k == 0) ? 16'h8000 : 16'h0000;
      run_frame(32'd0, 1'b0, fv_at, fv_cnt, busy_cnt);
      check($sformatf("decay%0d_fv_at", k), fv_at, 32'd17);
      exp_h[0] = (k == 0) ? 5'd31 : 5'd0;
      model_publish();
      check_outputs($sformatf("decay%0d", k));
      p0_exp = exp_q.pop_front();
      check($sformatf("decay%0d_p0_table", k), {27'd0, p0}, {27'd0, p0_exp});
    end

    // Overrun saturation: hold done high across many frames
    @(negedge clk);
    done = 1'b1;
    repeat (400) @(negedge clk);
    done = 1'b0;
    repeat (20) @(negedge clk);
    check("ovr_sat", {24'd0, overrun}, 32'd255);
    check("ovr_sat_busy", {31'd0, busy}, 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spectrum_bar_mapper.md
SPECTRUM_BAR_MAPPER -- requirements
Module: spectrum_bar_mapper

Interface
REQ-001 Parameter DECAY_DIV, default 4: number of published frames between 1-step peak decrements; legal range 1..255.
REQ-002 clk  input  1  system clock, the same clock that drives the FFT processor; all logic is rising-edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 done  input  1  one-cycle pulse from the FFT processor marking f0..f15 valid.
REQ-005 f0..f15  input  16 each  bin magnitudes, unsigned.
REQ-006 h0..h15  output  5 each  published bar heights, 0..31.
REQ-007 p0..p15  output  5 each  published peak-hold heights, 0..31.
REQ-008 frame_valid  output  1  one-cycle pulse when h*/p* update.
REQ-009 busy  output  1  high while a frame is being processed.
REQ-010 overrun  output  8  saturating count of dropped done pulses.

Function
REQ-011 FSM states are IDLE, PROC and PUBLISH; reset enters IDLE.
REQ-012 In IDLE, done=1 at edge N captures f0..f15 into a snapshot, clears the bin index to 0, and enters PROC.
REQ-013 PROC converts exactly one snapshot bin per cycle, bin i at edge N+1+i, into a shadow height; after bin 15 it enters PUBLISH.
REQ-014 The height conversion is: f=0 -> 0; otherwise p = MSB position (0..15), b = bit p-1 (b=0 when p=0), and height = min(31, 2p+b+1).
REQ-015 At edge N+17 (PUBLISH), all 16 shadow heights copy to h0..h15 simultaneously, peaks update, frame_valid=1 for one cycle, and the FSM returns to IDLE.
REQ-016 Latency from done to frame_valid is exactly 17 cycles; h*/p* are stable at all other times.
REQ-017 busy=1 in PROC and PUBLISH, and busy=0 in IDLE.
REQ-018 A done pulse while busy=1 is ignored and increments overrun; overrun saturates at 255.
REQ-019 done in the same cycle as the PUBLISH-to-IDLE transition is dropped and counted; a new frame is accepted only when the FSM is in IDLE.
REQ-020 Each peak update follows these rules:
- if h_new >= p_old, then p = h_new;
- else, on a decay frame, p = max(h_new, p_old-1);
- else p holds.
REQ-021 A decay-frame counter counts published frames modulo DECAY_DIV; a decay frame is one where the counter wraps to 0, and the counter increments at every PUBLISH.
REQ-022 The snapshot is isolated from input changes: f* may change at any time after the capture edge without affecting the frame in progress.

Reset
REQ-023 Reset assertion asynchronously forces the following, including mid-PROC or mid-PUBLISH:
- h*, p*, shadows and snapshot to 0;
- frame_valid=0, busy=0, overrun=0;
- decay counter and bin index to 0;
- FSM to IDLE.
REQ-024 Reset release is synchronised to clk; the first done is accepted no earlier than the second rising edge after deassertion.
REQ-025 After a reset that interrupts a frame, no frame_valid is produced for the interrupted frame.

Configuration
REQ-026 Macro SPECTRUM_PEAK_HOLD_EN, when defined, implements the peak registers, the decay counter and REQ-020/021.
REQ-027 Without SPECTRUM_PEAK_HOLD_EN:
- p0..p15 are constant 0;
- no peak or decay storage is synthesised;
- all other behaviour and latency are unchanged.

Verification
REQ-028 Conversion: f0=0x0000, f1=0x0001, f2=0x0100, f3=0x0180, f4=0x8000, f5=0xFFFF, then done -> at +17 cycles h0=0, h1=1, h2=17, h3=18, h4=31, h5=31, with frame_valid high for exactly 1 cycle.
REQ-029 Overrun: done at cycle 0, then done at cycles 5 and 17 -> exactly one frame_valid at cycle 17, overrun=2, busy high for cycles 1..17.
REQ-030 Peak decay (DECAY_DIV=4, EN defined): one frame with f0=0x8000 (h0=31), then 12 frames with f0=0 -> p0 = 31, 31, 31, 30, 30, 30, 30, 29, ... and h0=0 from the second frame onward.
REQ-031 Reset mid-frame: assert reset at done+8 for 3 cycles -> h*, p* and overrun are 0 immediately, no frame_valid follows, and the next done yields a normal frame at +17.
REQ-032 Input isolation: change all f* to 0xFFFF one cycle after the capture edge -> published heights reflect the captured values only.
REQ-033 Macro off: repeat the REQ-030 stimulus -> p0..p15 read 0 throughout, and h0 and the frame_valid timing are identical to the REQ-030 run.
